// File: rtl/ring8_decoder.sv
// Ring-pattern tracker for an 8-bit rotating one-hot sequence: acquires lock,
// flywheels over single glitches, and counts sequence errors.
module ring8_decoder #(
    parameter int unsigned LOCK_N = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE,
    input  logic [7:0] I,
    output logic [2:0] O,
    output logic       VALID,
    output logic       LOCK,
    output logic       ERR,
    output logic       REV,
    output logic [7:0] ERRCNT
);

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] ACQ     = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;
    localparam logic [1:0] SUSPECT = 2'd3;

    localparam logic [3:0] LOCK_CNT = LOCK_N[3:0];

    logic [1:0] state_q, state_d;
    logic [2:0] ref_q, ref_d;
    logic [3:0] good_q, good_d;
    logic [2:0] o_q, o_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       rev_q, rev_d;
    logic [7:0] errcnt_q, errcnt_d;

    logic       onehot;
    logic [2:0] idx;
    logic [2:0] ref_inc;
    logic [3:0] good_inc;
    logic       good_step;

    always_comb begin
        onehot = (I != '0) && ((I & (I - 8'd1)) == '0);
        idx    = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            if (I[b]) idx = b[2:0];
        end
        ref_inc   = ref_q + 3'd1;
        good_inc  = good_q + 4'd1;
        good_step = onehot && (idx == ref_inc);
    end

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        good_d   = good_q;
        o_d      = o_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        rev_d    = 1'b0;
        errcnt_d = errcnt_q;

        if (CE) begin
            valid_d = onehot;
            if (onehot) o_d = idx;

            case (state_q)
                HUNT: begin
                    if (onehot) begin
                        ref_d   = idx;
                        good_d  = '0;
                        state_d = ACQ;
                    end
                end
                ACQ: begin
                    if (good_step) begin
                        ref_d  = idx;
                        good_d = good_inc;
                        if (good_inc == LOCK_CNT) state_d = LOCKED;
                    end else if (onehot) begin
                        ref_d  = idx;
                        good_d = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (good_step) begin
                        ref_d = idx;
                        rev_d = (ref_q == 3'd7);
                    end else begin
                        // Flywheel: assume the missed step happened so a single glitch can recover.
                        ref_d   = ref_inc;
                        err_d   = 1'b1;
                        state_d = SUSPECT;
                    end
                end
                default: begin
                    if (good_step) begin
                        ref_d   = idx;
                        rev_d   = (ref_q == 3'd7);
                        state_d = LOCKED;
                    end else begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = HUNT;
                    end
                end
            endcase

            if (err_d && (errcnt_q != '1)) errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= HUNT;
            ref_q    <= '0;
            good_q   <= '0;
            o_q      <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rev_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            good_q   <= good_d;
            o_q      <= o_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            rev_q    <= rev_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign O      = o_q;
    assign VALID  = valid_q;
    assign LOCK   = (state_q == LOCKED) || (state_q == SUSPECT);
    assign ERR    = err_q;
    assign REV    = rev_q;
    assign ERRCNT = errcnt_q;

endmodule

// File: tb/tb_ring8_decoder.sv
// Scoreboard bench for ring8_decoder: two instances (LOCK_N=8 and LOCK_N=1)
// driven with the same stimulus and compared against a behavioural model.
module tb_ring8_decoder;

    typedef struct {
        int          st;      // 0 HUNT, 1 ACQ, 2 LOCKED, 3 SUSPECT
        int          refi;
        int          good;
        logic [2:0]  o;
        bit          valid;
        bit          err;
        bit          rev;
        int          errcnt;
    } mdl_t;

    typedef struct {
        logic [2:0] o;
        logic       valid;
        logic       lock;
        logic       err;
        logic       rev;
        logic [7:0] errcnt;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CE = 1'b0;
    logic [7:0] I = '0;

    logic [2:0] o8, o1;
    logic       valid8, valid1, lock8, lock1, err8, err1, rev8, rev1;
    logic [7:0] errcnt8, errcnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int rev_seen = 0;

    mdl_t m8, m1;
    exp_t q8[$];
    exp_t q1[$];

    ring8_decoder #(.LOCK_N(8)) u_dut8 (
        .CLK(CLK), .RESET(RESET), .CE(CE), .I(I),
        .O(o8), .VALID(valid8), .LOCK(lock8), .ERR(err8), .REV(rev8), .ERRCNT(errcnt8)
    );

    ring8_decoder #(.LOCK_N(1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .CE(CE), .I(I),
        .O(o1), .VALID(valid1), .LOCK(lock1), .ERR(err1), .REV(rev1), .ERRCNT(errcnt1)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mreset();
        mdl_t m;
        m.st = 0; m.refi = 0; m.good = 0; m.o = 3'd0;
        m.valid = 0; m.err = 0; m.rev = 0; m.errcnt = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(input mdl_t m_in, input int lock_n, input logic [7:0] x);
        mdl_t m;
        bit   oh;
        bit   gd;
        int   k;
        m  = m_in;
        oh = ($countones(x) == 1);
        k  = 0;
        for (int b = 0; b < 8; b++) if (x[b]) k = b;
        gd = oh && (k == (m.refi + 1) % 8);
        m.err = 0;
        m.rev = 0;
        m.valid = oh;
        if (oh) m.o = k[2:0];
        case (m.st)
            0: if (oh) begin m.refi = k; m.good = 0; m.st = 1; end
            1: begin
                if (gd) begin
                    m.refi = k; m.good = m.good + 1;
                    if (m.good == lock_n) m.st = 2;
                end else if (oh) begin
                    m.refi = k; m.good = 0;
                end else m.st = 0;
            end
            2: begin
                if (gd) begin m.rev = (m.refi == 7); m.refi = k; end
                else begin m.refi = (m.refi + 1) % 8; m.err = 1; m.st = 3; end
            end
            default: begin
                if (gd) begin m.rev = (m.refi == 7); m.refi = k; m.st = 2; end
                else begin m.err = 1; m.st = 0; m.good = 0; end
            end
        endcase
        if (m.err && m.errcnt < 255) m.errcnt = m.errcnt + 1;
        return m;
    endfunction

    function automatic exp_t outs(input mdl_t m);
        exp_t e;
        e.o = m.o; e.valid = m.valid; e.lock = (m.st == 2 || m.st == 3);
        e.err = m.err; e.rev = m.rev; e.errcnt = m.errcnt[7:0];
        return e;
    endfunction

    task automatic cmp(input string who, input exp_t got, input exp_t e);
        check({who, ".O"},      got.o,      e.o);
        check({who, ".VALID"},  got.valid,  e.valid);
        check({who, ".LOCK"},   got.lock,   e.lock);
        check({who, ".ERR"},    got.err,    e.err);
        check({who, ".REV"},    got.rev,    e.rev);
        check({who, ".ERRCNT"}, got.errcnt, e.errcnt);
    endtask

    function automatic exp_t got8();
        exp_t g;
        g.o = o8; g.valid = valid8; g.lock = lock8; g.err = err8; g.rev = rev8; g.errcnt = errcnt8;
        return g;
    endfunction

    function automatic exp_t got1();
        exp_t g;
        g.o = o1; g.valid = valid1; g.lock = lock1; g.err = err1; g.rev = rev1; g.errcnt = errcnt1;
        return g;
    endfunction

    task automatic pop_compare(input string tag);
        exp_t e;
        if (q8.size() == 0 || q1.size() == 0) begin
            check({tag, ".queue_empty"}, 1, 0);
        end else begin
            e = q8.pop_front(); cmp({tag, ".L8"}, got8(), e);
            e = q1.pop_front(); cmp({tag, ".L1"}, got1(), e);
        end
    endtask

    task automatic sample(input logic [7:0] x);
        @(negedge CLK);
        CE = 1'b1;
        I  = x;
        m8 = mstep(m8, 8, x);
        m1 = mstep(m1, 1, x);
        q8.push_back(outs(m8));
        q1.push_back(outs(m1));
        @(posedge CLK);
        #1;
        if (rev8) rev_seen++;
        pop_compare("sample");
    endtask

    // CE=0 cycle: model state is frozen and the pulses must read 0.
    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            CE = 1'b0;
            I  = 8'($urandom);
            m8.err = 0; m8.rev = 0;
            m1.err = 0; m1.rev = 0;
            q8.push_back(outs(m8));
            q1.push_back(outs(m1));
            @(posedge CLK);
            #1;
            pop_compare("idle");
        end
    endtask

    task automatic ring_run(input int start, input int count, input int gap);
        logic [7:0] one;
        one = 8'd1;
        for (int s = 0; s < count; s++) begin
            sample(one << ((start + s) % 8));
            if (gap > 0) idle(gap);
        end
    endtask

    initial begin
        m8 = mreset();
        m1 = mreset();

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        cmp("reset.L8", got8(), outs(m8));
        cmp("reset.L1", got1(), outs(m1));
        @(negedge CLK);
        RESET = 1'b0;

        // Clean acquisition, CE every 4th cycle: lock after the 9th sample
        ring_run(0, 8, 3);
        check("acq.lock_before_9th", lock8, 0);
        ring_run(0, 1, 3);
        check("acq.lock_after_9th", lock8, 1);
        check("acq.errcnt", errcnt8, 0);

        // Two full revolutions while locked: one REV per wrap
        rev_seen = 0;
        ring_run(1, 16, 1);
        check("rev.count", rev_seen, 2);

        // Single glitch: 30 in place of 10, then recovery with 20
        ring_run(1, 3, 0);      // 02,04,08
        sample(8'h30);
        check("glitch.err", err8, 1);
        check("glitch.lock", lock8, 1);
        check("glitch.valid", valid8, 0);
        check("glitch.errcnt", errcnt8, 1);
        sample(8'h20);
        check("glitch.recover_lock", lock8, 1);
        ring_run(6, 2, 0);      // 40,80

        // Double error: 00,00 drops lock, next one-hot enters ACQ
        sample(8'h00);
        sample(8'h00);
        check("dbl.lock", lock8, 0);
        check("dbl.errcnt", errcnt8, 3);
        sample(8'h04);
        check("dbl.acq_lock", lock8, 0);

        // LOCK_N=1 boundary: one-hot enters ACQ, next good step locks
        sample(8'h00);
        sample(8'h00);
        sample(8'h01);
        sample(8'h02);
        check("lockn1.lock", lock1, 1);
        check("lockn8.nolock", lock8, 0);

        // Saturation: repeated lock / double-error cycles
        for (int r = 0; r < 300; r++) begin
            ring_run(0, 9, 0);
            sample(8'h00);
            sample(8'h00);
        end
        check("sat.errcnt8", errcnt8, 8'hFF);
        check("sat.errcnt1", errcnt1, 8'hFF);

        // CE gating: random I with CE=0 for 100 cycles
        ring_run(0, 9, 0);
        idle(100);

        // Async reset mid-lock, between clock edges
        check("rst.locked_before", lock8, 1);
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        m8 = mreset();
        m1 = mreset();
        cmp("async_rst.L8", got8(), outs(m8));
        cmp("async_rst.L1", got1(), outs(m1));

        // CE sample coincident with reset is discarded
        @(negedge CLK);
        CE = 1'b1;
        I  = 8'h01;
        @(posedge CLK);
        #1;
        cmp("rst_ce.L8", got8(), outs(m8));
        @(negedge CLK);
        RESET = 1'b0;
        CE    = 1'b0;

        // First post-reset sample is a HUNT sample
        sample(8'h02);
        sample(8'h04);
        check("post_rst.lock8", lock8, 0);
        check("post_rst.lock1", lock1, 1);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
